xor_reduce_pipe: RTL and testbench

XOR_REDUCE_PIPE -- requirements
Module: xor_reduce_pipe

---
 rtl/xor_reduce_pkg.sv | 27 ++
 rtl/xor_reduce_stage.sv | 66 ++++++
 rtl/xor_reduce_pipe.sv | 133 +++++++++++++
 tb/tb_xor_reduce_pipe.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/xor_reduce_pkg.sv
// Shared defaults, per-stage width helper and pipeline sideband type for xor_reduce_pipe.
// XOR_REDUCE_CHECK_EN adds the expected-parity bit to the sideband.
package xor_reduce_pkg;

  localparam int DEF_WIDTH  = 11;
  localparam int DEF_LEAF   = 4;
  localparam int DEF_STAGES = 2;
  localparam int DEF_CNTW   = 16;

  typedef struct packed {
    logic first;
    logic last;
`ifdef XOR_REDUCE_CHECK_EN
    logic exp;
`endif
  } side_t;

  // Registered partial-XOR count after stage s (1-based); the last stage is always 1 bit.
  function automatic int stage_out_w(input int width, input int leaf, input int stages, input int s);
    int w;
    w = width;
    if (s >= stages) return 1;
    for (int k = 0; k < s; k++) w = (w + leaf - 1) / leaf;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/xor_reduce_stage.sv
// One registered LEAF-ary XOR reduction level with valid, sideband and global enable.
module xor_reduce_stage
  import xor_reduce_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OUT_W = 1,
  parameter int LEAF  = DEF_LEAF,
  parameter bit INV   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  input  side_t            in_side,
  output logic             out_vld,
  output logic [OUT_W-1:0] out_data,
  output side_t            out_side
);

  localparam int GRP = (OUT_W == 1) ? WIDTH : LEAF;

  logic             vld_q, vld_d;
  logic [OUT_W-1:0] data_q, data_d, red;
  side_t            side_q, side_d;
  int               j;

  // Bits past the live width are zero padding; folding them into the top group keeps indices in range.
  always_comb begin
    red = '0;
    j   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      j      = ((i / GRP) < OUT_W) ? (i / GRP) : (OUT_W - 1);
      red[j] = red[j] ^ in_data[i];
    end
    red[0] = red[0] ^ INV;
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    side_d = side_q;
    if (en) begin
      vld_d  = in_vld;
      data_d = red;
      side_d = in_side;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      side_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      side_q <= side_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = data_q;
  assign out_side = side_q;

endmodule

// File: rtl/xor_reduce_pipe.sv
// Pipelined XOR/XNOR word reduction with frame parity accumulator and word counter.
// Define XOR_REDUCE_CHECK_EN to add the EXP/ERR/ERR_STICKY frame-parity checker.
module xor_reduce_pipe
  import xor_reduce_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LEAF   = DEF_LEAF,
  parameter int STAGES = DEF_STAGES,
  parameter int INVERT = 0,
  parameter int CNTW   = DEF_CNTW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             D_VALID,
  output logic             D_READY,
  input  logic [WIDTH-1:0] D,
  input  logic             D_FIRST,
  input  logic             D_LAST,
  output logic             Z_VALID,
  input  logic             Z_READY,
  output logic             Z,
  output logic             Z_LAST,
  output logic             ACC,
  output logic [CNTW-1:0]  WORDS
`ifdef XOR_REDUCE_CHECK_EN
  ,
  input  logic             EXP,
  output logic             ERR,
  output logic             ERR_STICKY
`endif
);

  logic                          en;
  logic [STAGES:0]               vld_pipe;
  logic [STAGES:0][WIDTH-1:0]    dat_pipe;
  side_t [STAGES:0]              side_pipe;

  assign en      = !Z_VALID | Z_READY;
  assign D_READY = en;

  assign vld_pipe[0]        = D_VALID;
  assign dat_pipe[0]        = D;
  assign side_pipe[0].first = D_FIRST;
  assign side_pipe[0].last  = D_LAST;
`ifdef XOR_REDUCE_CHECK_EN
  assign side_pipe[0].exp   = EXP;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int OW = stage_out_w(WIDTH, LEAF, STAGES, s + 1);
    logic [OW-1:0] dout;

    xor_reduce_stage #(
      .WIDTH (WIDTH),
      .OUT_W (OW),
      .LEAF  (LEAF),
      .INV   ((s == STAGES - 1) && (INVERT != 0))
    ) u_stage (
      .clk      (CLK),
      .rst      (RST),
      .en       (en),
      .in_vld   (vld_pipe[s]),
      .in_data  (dat_pipe[s]),
      .in_side  (side_pipe[s]),
      .out_vld  (vld_pipe[s+1]),
      .out_data (dout),
      .out_side (side_pipe[s+1])
    );

    assign dat_pipe[s+1] = WIDTH'(dout);
  end

  // Last stage holds a single bit; the rest of its lane is zero.
  assign Z_VALID = vld_pipe[STAGES];
  assign Z       = ^dat_pipe[STAGES];
  assign Z_LAST  = side_pipe[STAGES].last;

  logic            open_q, open_d;
  logic            acc_q, acc_d;
  logic [CNTW-1:0] words_q, words_d;
  logic            restart, acc_now, hs;
  logic [CNTW-1:0] words_base, words_now;

  // Frame totals include the word currently presented, so they stay stable across a stall.
  always_comb begin
    hs         = Z_VALID & Z_READY;
    restart    = side_pipe[STAGES].first | !open_q;
    acc_now    = (restart ? 1'b0 : acc_q) ^ Z;
    words_base = restart ? '0 : words_q;
    words_now  = (&words_base) ? words_base : words_base + CNTW'(1);
    open_d     = open_q;
    acc_d      = acc_q;
    words_d    = words_q;
    if (hs) begin
      open_d  = !Z_LAST;
      acc_d   = acc_now;
      words_d = words_now;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      open_q  <= 1'b0;
      acc_q   <= 1'b0;
      words_q <= '0;
    end else begin
      open_q  <= open_d;
      acc_q   <= acc_d;
      words_q <= words_d;
    end
  end

  assign ACC   = Z_VALID & acc_now;
  assign WORDS = Z_VALID ? words_now : '0;

`ifdef XOR_REDUCE_CHECK_EN
  logic err, sticky_q, sticky_d;

  always_comb begin
    err      = hs & Z_LAST & (acc_now != side_pipe[STAGES].exp);
    sticky_d = sticky_q | err;
  end

  always_ff @(posedge CLK) begin
    if (RST) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ERR        = err;
  assign ERR_STICKY = sticky_q;
`endif

endmodule

// File: tb/tb_xor_reduce_pipe.sv
// Directed bench for xor_reduce_pipe: a default instance plus an INVERT=1, CNTW=2 instance on shared stimulus.
module tb_xor_reduce_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv, df, dl, zr;
  logic [10:0] dd;
  logic        d_ready, z_valid, z, z_last, acc;
  logic [15:0] words;
  logic        i_d_ready, i_z_valid, i_z, i_z_last, i_acc;
  logic [1:0]  i_words;
`ifdef XOR_REDUCE_CHECK_EN
  logic        exp_in, err, sticky, i_err, i_sticky;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xor_reduce_pipe dut (
    .CLK(clk), .RST(rst), .D_VALID(dv), .D_READY(d_ready), .D(dd), .D_FIRST(df), .D_LAST(dl),
    .Z_VALID(z_valid), .Z_READY(zr), .Z(z), .Z_LAST(z_last), .ACC(acc), .WORDS(words)
`ifdef XOR_REDUCE_CHECK_EN
    , .EXP(exp_in), .ERR(err), .ERR_STICKY(sticky)
`endif
  );

  xor_reduce_pipe #(.INVERT(1), .CNTW(2)) dut_inv (
    .CLK(clk), .RST(rst), .D_VALID(dv), .D_READY(i_d_ready), .D(dd), .D_FIRST(df), .D_LAST(dl),
    .Z_VALID(i_z_valid), .Z_READY(zr), .Z(i_z), .Z_LAST(i_z_last), .ACC(i_acc), .WORDS(i_words)
`ifdef XOR_REDUCE_CHECK_EN
    , .EXP(exp_in), .ERR(i_err), .ERR_STICKY(i_sticky)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expz(input string tag, input logic ez, input logic el, input logic ea, input int ew);
    chk({tag, ".z"},     z,      ez);
    chk({tag, ".last"},  z_last, el);
    chk({tag, ".acc"},   acc,    ea);
    chk({tag, ".words"}, words,  ew);
  endtask

  // Called just after a negedge; returns just after the negedge where the word is on Z.
  task automatic xfer(input logic [10:0] d, input logic f, input logic l);
    dv = 1'b1; dd = d; df = f; dl = l;
    #1 chk("acc_rdy", d_ready, 1);
    @(negedge clk);
    dv = 1'b0; df = 1'b0; dl = 1'b0;
    #1 chk("lat1", z_valid, 0);
    @(negedge clk);
    #1 chk("lat2", z_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; dv = 1'b0; df = 1'b0; dl = 1'b0; zr = 1'b1; dd = '0;
`ifdef XOR_REDUCE_CHECK_EN
    exp_in = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst.zv", z_valid, 0);
    chk("rst.z", z, 0);
    chk("rst.last", z_last, 0);
    chk("rst.acc", acc, 0);
    chk("rst.words", words, 0);
    rst = 1'b0;
    chk("rst.rdy", d_ready, 1);

    xfer(11'h7FF, 0, 0); expz("w7ff", 1, 0, 1, 1);
    chk("w7ff.inv", i_z, 0);
    xfer(11'h000, 0, 0); expz("w000", 0, 0, 1, 2);

    // FIRST mid-frame discards the open frame
    xfer(11'h001, 1, 0); expz("f1", 1, 0, 1, 1);
    xfer(11'h003, 0, 0); expz("f2", 0, 0, 1, 2);
    xfer(11'h007, 0, 1); expz("f3", 1, 1, 0, 3);
    xfer(11'h013, 0, 0); expz("after_last", 1, 0, 1, 1);

    for (int k = 0; k < 5; k++) begin
      xfer(11'h000, k == 0, 0);
      chk("sat.words", words, k + 1);
      chk("sat.iwords", i_words, (k < 3) ? k + 1 : 3);
      chk("sat.iacc", i_acc, (k % 2 == 0) ? 1 : 0);
    end

    xfer(11'h000, 1, 1); expz("single", 0, 1, 0, 1);
    chk("single.iz", i_z, 1);
    chk("single.iacc", i_acc, 1);
    chk("single.iwords", i_words, 1);
    chk("single.ilast", i_z_last, 1);

    // Backpressure: hold output for 5 cycles with a word waiting at the input
    dv = 1'b1; dd = 11'h001; df = 1'b1; dl = 1'b0;
    @(negedge clk);
    dd = 11'h003; df = 1'b0;
    @(negedge clk);
    #1 chk("stl.zv0", z_valid, 1);
    zr = 1'b0; dd = 11'h007; dl = 1'b1;
    #1 chk("stl.rdy0", d_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("stl.zv", z_valid, 1);
      chk("stl.rdy", d_ready, 0);
      expz("stl", 1, 0, 1, 1);
    end
    zr = 1'b1;
    @(negedge clk);
    #1 dv = 1'b0; dl = 1'b0;
    chk("rel_b.zv", z_valid, 1);
    expz("rel_b", 0, 0, 1, 2);
    @(negedge clk);
    #1 chk("rel_c.zv", z_valid, 1);
    expz("rel_c", 1, 1, 0, 3);
    @(negedge clk);
    #1 chk("nodup", z_valid, 0);

`ifdef XOR_REDUCE_CHECK_EN
    xfer(11'h001, 1, 0);
    chk("chk.err0", err, 0);
    xfer(11'h003, 0, 0);
    exp_in = 1'b1;
    xfer(11'h007, 0, 1);
    chk("chk.err", err, 1);
    @(negedge clk);
    #1 chk("chk.pulse", err, 0);
    chk("chk.sticky", sticky, 1);
    exp_in = 1'b0;
`endif

    // Reset with a frame open and two words in flight
    dv = 1'b1; dd = 11'h001; df = 1'b1;
    @(negedge clk);
    dd = 11'h003; df = 1'b0;
    @(negedge clk);
    dd = 11'h007;
    @(negedge clk);
    #1 rst = 1'b1; dv = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst.zv", z_valid, 0);
    chk("mrst.z", z, 0);
    chk("mrst.last", z_last, 0);
    chk("mrst.acc", acc, 0);
    chk("mrst.words", words, 0);
`ifdef XOR_REDUCE_CHECK_EN
    chk("mrst.sticky", sticky, 0);
`endif
    rst = 1'b0;
    chk("mrst.rdy", d_ready, 1);
    xfer(11'h001, 0, 1); expz("post_rst", 1, 1, 1, 1);
    @(negedge clk);
    #1 chk("post_rst.idle", z_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
